// File: rtl/cla_seq_adder_ctrl.sv
// Sequential wide adder built around one shared 4-bit carry-lookahead slice.
// A WIDTH-bit add is processed one nibble per clock, LSB nibble first, with the
// inter-nibble carry held in a register.
//
// Ports:
//   clk    system clock, rising-edge
//   rst    synchronous active-high reset (priority over start)
//   start  request, accepted only when busy=0 (IDLE or DONE)
//   a, b   operands, captured on an accepted start
//   cin    carry into nibble 0, captured on an accepted start
//   busy   high for the NIB cycles of an operation
//   done   one-cycle pulse; sum/cout valid from this cycle on
//   sum    result of the last completed operation
//   cout   carry out of the top nibble of the last completed operation
module cla_seq_adder_ctrl #(
  parameter int unsigned WIDTH = 16  // multiple of 4, >= 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LastNib = CW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Nibble select: shift the latched operands down by 4*cnt.
  logic [CW+1:0]    shamt;
  logic [WIDTH-1:0] opa_sh, opb_sh;
  logic [3:0]       nib_a, nib_b;

  assign shamt  = {cnt_q, 2'b00};
  assign opa_sh = opa_q >> shamt;
  assign opb_sh = opb_q >> shamt;
  assign nib_a  = opa_sh[3:0];
  assign nib_b  = opb_sh[3:0];

  // 4-bit carry-lookahead slice.
  logic [3:0] gen, prop, slice_sum;
  logic [4:0] c;

  always_comb begin
    gen  = nib_a & nib_b;
    prop = nib_a ^ nib_b;
    c[0] = carry_q;
    c[1] = gen[0] | (prop[0] & c[0]);
    c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c[0]);
    c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0]) |
           (prop[2] & prop[1] & prop[0] & c[0]);
    c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1]) |
           (prop[3] & prop[2] & prop[1] & gen[0]) |
           (prop[3] & prop[2] & prop[1] & prop[0] & c[0]);
    slice_sum = prop ^ c[3:0];
  end

  // Result register with nibble cnt replaced by the slice sum.
  logic [WIDTH-1:0] nib_mask, nib_val, res_merged;

  assign nib_mask   = {{(WIDTH-4){1'b0}}, 4'hF} << shamt;
  assign nib_val    = {{(WIDTH-4){1'b0}}, slice_sum} << shamt;
  assign res_merged = (res_q & ~nib_mask) | nib_val;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start exactly like IDLE for back-to-back operation.
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d   = res_merged;
        carry_d = c[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastNib) begin
          sum_d   = res_merged;
          cout_d  = c[4];
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit additions with a single shared 4-bit CLA slice (cla_adder: a[3:0], b[3:0], cin -> sum[3:0], cout), one nibble per clock, LSB nibble first. The ripple carry is held in a register between nibbles. A start/busy/done handshake lets a host issue wide adds without instantiating a wide adder. It sits between a host register interface and one cla_adder instance, which it owns.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8; NIB = WIDTH/4 nibbles per operation.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in to nibble 0, captured on accepted start
busy  output  1  operation in progress; start ignored while high
done  output  1  single-cycle pulse; sum/cout valid from this cycle on
sum  output  WIDTH  result of last completed operation
cout  output  1  carry-out of nibble NIB-1 of last completed operation

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry reg=0, nibble counter=0, operand regs=0. rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b into operand regs, latch cin into carry reg, counter=0, go RUN. start=0 -> stay IDLE.
- RUN: each edge feeds nibble [4i+3:4i] of the latched operands plus the carry reg to cla_adder; the slice sum is written into nibble i of an internal result reg; carry reg <= slice cout; counter increments.
- The edge processing nibble NIB-1 (edge k+NIB) copies the full result to sum, slice cout to cout, and goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. start=1 at that edge is accepted as in IDLE, giving back-to-back operation. Otherwise the block returns to IDLE.
- busy=1 exactly in RUN, i.e. the cycles following edges k..k+NIB-1 (NIB cycles). done is high in the cycle after edge k+NIB.
- Throughput: one operation per NIB+1 cycles.
- start while busy=1: ignored, no latch, no queueing. Input changes on a/b/cin during RUN have no effect.
- sum/cout hold the previous result throughout RUN and change only at the final RUN edge. They hold indefinitely in IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. No overflow flag.
- Counter width = ceil(log2(NIB)). Counter wrap never occurs, because the transition to DONE happens at count NIB-1.
- rst asserted mid-RUN: abort immediately. No done pulse; sum/cout cleared to 0.

Test Plan:
- WIDTH=16, rst 2 cycles, then start with a=0x00FF, b=0x0001, cin=0 -> busy high 4 cycles, done pulse 5th cycle after start edge, sum=0x0100, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples all 4 nibbles). Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. During RUN change a to 0xAAAA and pulse start -> result unchanged, no extra done, busy timing unchanged.
- Back-to-back: assert start in the done cycle with a=0x8000, b=0x8000, cin=0 -> new op accepted, next done 5 cycles later with sum=0x0000, cout=1. The previous sum is held until then.
- Reset mid-op: start a=0x0F0F, b=0x0101, assert rst for 1 cycle at the 2nd RUN cycle -> busy=0, done never pulses, sum=0, cout=0. A following start with a=0x0F0F, b=0x0101 -> sum=0x1010.
- Random: 200 random a/b/cin with WIDTH=16 and WIDTH=8, compared against a behavioural a+b+cin. Check done is a single-cycle pulse and busy width equals NIB.
